// File: rtl/hamming_link_ctrl.sv
// hamming_link_ctrl
//   Sequencer for the Hamming(7,4) link self-test. Each accepted start runs
//   one nibble through encode -> error injection -> decode -> check and
//   publishes the codeword, syndrome, corrected nibble and pass/fail status,
//   plus saturating run and failure counters.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   single-cycle run request (honoured only in IDLE)
//   data_in    in   [3:0] nibble under test {d3,d2,d1,d0}
//   err_a      in   [2:0] first injected error position (0 = none)
//   err_b      in   [2:0] second injected error position (0 = none)
//   busy       out  run in progress
//   done       out  one-cycle completion pulse
//   codeword   out  [6:0] {d3,d2,d1,p4,d0,p2,p1} before injection
//   syndrome   out  [2:0] decoder syndrome (error position)
//   corrected  out  [3:0] decoded, corrected nibble
//   pass       out  corrected equals latched data_in
//   err_seen   out  syndrome nonzero
//   run_count  out  [CNT_W-1:0] completed runs, saturating
//   fail_count out  [CNT_W-1:0] failed runs, saturating
module hamming_link_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       data_in,
  input  logic [2:0]       err_a,
  input  logic [2:0]       err_b,
  output logic             busy,
  output logic             done,
  output logic [6:0]       codeword,
  output logic [2:0]       syndrome,
  output logic [3:0]       corrected,
  output logic             pass,
  output logic             err_seen,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] fail_count
);

  typedef enum logic [2:0] {IDLE, ENC, INJ, DEC, CHK} state_t;

  state_t           state_q, state_d;
  logic [3:0]       data_q, data_d;
  logic [2:0]       erra_q, erra_d;
  logic [2:0]       errb_q, errb_d;
  logic [6:0]       cw_q, cw_d;
  logic [6:0]       rx_q, rx_d;
  logic [2:0]       syn_q, syn_d;
  logic [3:0]       corr_q, corr_d;
  logic             pass_q, pass_d;
  logic             seen_q, seen_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] fail_q, fail_d;

  // Position k (1..7) maps to codeword bit k-1; position 0 means no bit.
  function automatic logic [6:0] onehot7(input logic [2:0] k);
    logic [6:0] m;
    m = '0;
    if (k != 3'd0) m[k - 3'd1] = 1'b1;
    return m;
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  function automatic logic [2:0] calc_syn(input logic [6:0] r);
    logic s1, s2, s4;
    s1 = r[0] ^ r[2] ^ r[4] ^ r[6];
    s2 = r[1] ^ r[2] ^ r[5] ^ r[6];
    s4 = r[3] ^ r[4] ^ r[5] ^ r[6];
    return {s4, s2, s1};
  endfunction

  logic [2:0] syn_c;
  logic [6:0] fixed_c;

  always_comb begin
    syn_c   = calc_syn(rx_q);
    fixed_c = rx_q ^ onehot7(syn_c);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    erra_d  = erra_q;
    errb_d  = errb_q;
    cw_d    = cw_q;
    rx_d    = rx_q;
    syn_d   = syn_q;
    corr_d  = corr_q;
    pass_d  = pass_q;
    seen_d  = seen_q;
    done_d  = 1'b0;
    run_d   = run_q;
    fail_d  = fail_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = data_in;
          erra_d  = err_a;
          errb_d  = err_b;
          state_d = ENC;
        end
      end
      ENC: begin
        cw_d    = encode(data_q);
        state_d = INJ;
      end
      INJ: begin
        // Equal nonzero positions cancel in the XOR, leaving the word intact.
        rx_d    = cw_q ^ onehot7(erra_q) ^ onehot7(errb_q);
        state_d = DEC;
      end
      DEC: begin
        syn_d   = syn_c;
        corr_d  = {fixed_c[6], fixed_c[5], fixed_c[4], fixed_c[2]};
        state_d = CHK;
      end
      CHK: begin
        pass_d = (corr_q == data_q);
        seen_d = (syn_q != 3'd0);
        if (run_q != '1) run_d = run_q + CNT_W'(1);
        if ((corr_q != data_q) && (fail_q != '1)) fail_d = fail_q + CNT_W'(1);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      erra_q  <= '0;
      errb_q  <= '0;
      cw_q    <= '0;
      rx_q    <= '0;
      syn_q   <= '0;
      corr_q  <= '0;
      pass_q  <= 1'b0;
      seen_q  <= 1'b0;
      done_q  <= 1'b0;
      run_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      erra_q  <= erra_d;
      errb_q  <= errb_d;
      cw_q    <= cw_d;
      rx_q    <= rx_d;
      syn_q   <= syn_d;
      corr_q  <= corr_d;
      pass_q  <= pass_d;
      seen_q  <= seen_d;
      done_q  <= done_d;
      run_q   <= run_d;
      fail_q  <= fail_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign codeword   = cw_q;
  assign syndrome   = syn_q;
  assign corrected  = corr_q;
  assign pass       = pass_q;
  assign err_seen   = seen_q;
  assign run_count  = run_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_hamming_link_ctrl.sv
// Directed testbench for hamming_link_ctrl: a default-width instance for the
// functional tests and a CNT_W=2 instance for counter saturation.
module tb_hamming_link_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, reset2, start2;
  logic [3:0] data_in;
  logic [2:0] err_a, err_b;

  logic       busy, done, pass, err_seen;
  logic [6:0] codeword;
  logic [2:0] syndrome;
  logic [3:0] corrected;
  logic [7:0] run_count, fail_count;

  logic       busy2, done2, pass2, err_seen2;
  logic [6:0] codeword2;
  logic [2:0] syndrome2;
  logic [3:0] corrected2;
  logic [1:0] run_count2, fail_count2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  hamming_link_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .err_a(err_a), .err_b(err_b), .busy(busy), .done(done),
    .codeword(codeword), .syndrome(syndrome), .corrected(corrected),
    .pass(pass), .err_seen(err_seen), .run_count(run_count),
    .fail_count(fail_count)
  );

  hamming_link_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .data_in(data_in),
    .err_a(err_a), .err_b(err_b), .busy(busy2), .done(done2),
    .codeword(codeword2), .syndrome(syndrome2), .corrected(corrected2),
    .pass(pass2), .err_seen(err_seen2), .run_count(run_count2),
    .fail_count(fail_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start in cycle T, return in cycle T+5 with done checked.
  task automatic run(input logic [3:0] d, input logic [2:0] a, input logic [2:0] b);
    data_in = d; err_a = a; err_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_t1", 32'(busy), 32'd1);
    repeat (3) tick();
    check("done_t4", 32'(done), 32'd0);
    tick();
    check("done_t5", 32'(done), 32'd1);
    check("busy_t5", 32'(busy), 32'd0);
  endtask

  task automatic run2(input logic [3:0] d, input logic [2:0] a, input logic [2:0] b);
    data_in = d; err_a = a; err_b = b; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (4) tick();
    check("done2_t5", 32'(done2), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; reset2 = 1'b1; start2 = 1'b0;
    data_in = '0; err_a = '0; err_b = '0;
    repeat (2) tick();
    // reset together with start: start dropped
    start = 1'b1; data_in = 4'h7;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cw", 32'(codeword), 32'd0);
    check("rst_syn", 32'(syndrome), 32'd0);
    check("rst_corr", 32'(corrected), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_runs", 32'(run_count), 32'd0);

    // Test 1: clean run of 4'hB, latency checked cycle by cycle
    data_in = 4'hB; err_a = 3'd0; err_b = 3'd0; start = 1'b1;
    tick();
    start = 1'b0; data_in = 4'h0;   // later input changes must not matter
    check("t1_busy1", 32'(busy), 32'd1);
    tick();
    check("t1_cw", 32'(codeword), 32'h55);
    repeat (2) tick();
    check("t1_syn", 32'(syndrome), 32'd0);
    check("t1_corr", 32'(corrected), 32'hB);
    check("t1_done4", 32'(done), 32'd0);
    tick();
    check("t1_done5", 32'(done), 32'd1);
    check("t1_busy5", 32'(busy), 32'd0);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_seen", 32'(err_seen), 32'd0);
    check("t1_runs", 32'(run_count), 32'd1);
    tick();
    check("t1_done6", 32'(done), 32'd0);

    // Test 2: single error at position 5
    run(4'hB, 3'd5, 3'd0);
    check("t2_syn", 32'(syndrome), 32'd5);
    check("t2_corr", 32'(corrected), 32'hB);
    check("t2_pass", 32'(pass), 32'd1);
    check("t2_seen", 32'(err_seen), 32'd1);
    check("t2_fails", 32'(fail_count), 32'd0);

    // Test 3: double error 5,3 aliases to position 6
    run(4'hB, 3'd5, 3'd3);
    check("t3_syn", 32'(syndrome), 32'd6);
    check("t3_corr", 32'(corrected), 32'hC);
    check("t3_pass", 32'(pass), 32'd0);
    check("t3_fails", 32'(fail_count), 32'd1);
    check("t3_runs", 32'(run_count), 32'd3);

    // Test 4: equal positions cancel
    run(4'h6, 3'd4, 3'd4);
    check("t4_syn", 32'(syndrome), 32'd0);
    check("t4_pass", 32'(pass), 32'd1);
    check("t4_seen", 32'(err_seen), 32'd0);

    // Ignored start at T+2, accepted start at T+5
    data_in = 4'h3; err_a = 3'd0; err_b = 3'd0; start = 1'b1;
    tick();                                  // T+1
    start = 1'b0;
    tick();                                  // T+2
    data_in = 4'hA; err_a = 3'd1; start = 1'b1;
    tick();                                  // T+3
    start = 1'b0;
    repeat (2) tick();                       // T+5
    check("ig_done", 32'(done), 32'd1);
    check("ig_corr", 32'(corrected), 32'h3);
    check("ig_syn", 32'(syndrome), 32'd0);
    data_in = 4'h6; err_a = 3'd7; err_b = 3'd0; start = 1'b1;
    tick();                                  // T+6
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    repeat (4) tick();                       // T+10
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_corr", 32'(corrected), 32'h6);
    check("b2b_syn", 32'(syndrome), 32'd7);
    check("b2b_runs", 32'(run_count), 32'd6);

    // Reset at T+3 aborts the run
    data_in = 4'h9; err_a = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();                       // T+3
    reset = 1'b1;
    tick();                                  // T+4
    reset = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_cw", 32'(codeword), 32'd0);
    check("ab_pass", 32'(pass), 32'd0);
    check("ab_runs", 32'(run_count), 32'd0);
    check("ab_fails", 32'(fail_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab_nodone", 32'(done), 32'd0);
    end
    run(4'h9, 3'd2, 3'd0);
    check("ab_syn", 32'(syndrome), 32'd2);
    check("ab_corr", 32'(corrected), 32'h9);
    check("ab_run1", 32'(run_count), 32'd1);

    // Sweep: all nibbles x single error positions 0..7
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int d = 0; d < 16; d++) begin
      for (int a = 0; a < 8; a++) begin
        run(4'(d), 3'(a), 3'd0);
        check("sw_pass", 32'(pass), 32'd1);
        check("sw_syn", 32'(syndrome), 32'(a));
        check("sw_corr", 32'(corrected), 32'(d));
      end
    end
    check("sw_runs", 32'(run_count), 32'd128);
    check("sw_fails", 32'(fail_count), 32'd0);

    // Saturation with CNT_W=2
    reset2 = 1'b0;
    for (int i = 0; i < 3; i++) run2(4'hB, 3'd5, 3'd3);
    check("sat_fail3", 32'(fail_count2), 32'd3);
    for (int i = 0; i < 2; i++) run2(4'hB, 3'd5, 3'd3);
    check("sat_fails", 32'(fail_count2), 32'd3);
    check("sat_runs", 32'(run_count2), 32'd3);
    check("sat_pass", 32'(pass2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
